demux4_fifo: RTL and testbench



---
 rtl/demux4_fifo_pkg.sv | 18 +
 rtl/demux4_fifo_fifo_sync.sv | 56 +++++
 rtl/demux4_fifo.sv | 50 +++++
 tb/tb_demux4_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/demux4_fifo_pkg.sv
// rtl/demux4_fifo_pkg.sv - shared channel count, widths and select type for the 1:4 distributor
package demux4_fifo_pkg;

   localparam int WIDTH_DEFAULT = 32;
   localparam int DEPTH_DEFAULT = 2;
   localparam int NUM_CH        = 4;

   typedef logic [1:0] ch_sel_t;

   // One-hot channel strobe for a select value.
   function automatic logic [NUM_CH-1:0] sel_onehot(input ch_sel_t sel);
      logic [NUM_CH-1:0] oh;
      oh = '0;
      oh[sel] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/demux4_fifo_fifo_sync.sv
// rtl/demux4_fifo_fifo_sync.sv - single-clock FIFO with registered count and flags
module fifo_sync #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   // Flush wins over both sides; a push into a full FIFO is refused even when it pops.
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/demux4_fifo.sv
// rtl/demux4_fifo.sv - registered 1:4 word distributor with a FIFO per output channel
module demux4_fifo
   import demux4_fifo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   flush,
   input  logic                                   in_valid,
   input  ch_sel_t                                in_sel,
   input  logic [WIDTH-1:0]                       in_data,
   output logic                                   in_ready,
   output logic [NUM_CH-1:0]                      out_valid,
   output logic [NUM_CH*WIDTH-1:0]                out_data,
   input  logic [NUM_CH-1:0]                      out_ready,
   output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]    occupancy
);

   localparam int OCC_W = $clog2(DEPTH) + 1;

   logic [NUM_CH-1:0] full_v;
   logic [NUM_CH-1:0] empty_v;
   logic [NUM_CH-1:0] push_v;

   // Ready looks only at the targeted channel's registered full flag, never at out_ready.
   assign in_ready = ~flush & ~full_v[in_sel];
   assign push_v   = (in_valid & in_ready) ? sel_onehot(in_sel) : '0;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      fifo_sync #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .flush (flush),
         .push  (push_v[k]),
         .pop   (out_ready[k]),
         .wdata (in_data),
         .rdata (out_data[k*WIDTH +: WIDTH]),
         .count (occupancy[k*OCC_W +: OCC_W]),
         .full  (full_v[k]),
         .empty (empty_v[k])
      );
      assign out_valid[k] = ~empty_v[k];
   end

endmodule

// File: tb/tb_demux4_fifo.sv
// tb/tb_demux4_fifo.sv - self-checking bench for demux4_fifo against a queue model
module tb_demux4_fifo;
   import demux4_fifo_pkg::*;

   localparam int W  = 32;
   localparam int D  = 2;
   localparam int OW = $clog2(D) + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   ch_sel_t           in_sel = 2'd0;
   logic [W-1:0]      in_data = '0;
   logic              in_ready;
   logic [3:0]        out_valid;
   logic [4*W-1:0]    out_data;
   logic [3:0]        out_ready = 4'b0;
   logic [4*OW-1:0]   occupancy;

   int checks = 0;
   int failures = 0;
   bit run = 1'b0;

   logic [W-1:0] mq [4][$];

   demux4_fifo #(.WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   function automatic logic exp_ready();
      return !flush && (mq[in_sel].size() < D);
   endfunction

   // Model: refused-if-full push, independent pops, flush clears everything.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) mq[k].delete();
      end else if (flush) begin
         for (int k = 0; k < 4; k++) mq[k].delete();
      end else begin
         logic acc;
         acc = in_valid && exp_ready();
         for (int k = 0; k < 4; k++)
            if (out_ready[k] && mq[k].size() > 0) void'(mq[k].pop_front());
         if (acc) mq[in_sel].push_back(in_data);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run) begin
         chk("cmp_in_ready", 32'(in_ready), 32'(exp_ready()));
         for (int k = 0; k < 4; k++) begin
            chk("cmp_out_valid", 32'(out_valid[k]), 32'(mq[k].size() != 0));
            chk("cmp_out_data", out_data[k*W +: W], (mq[k].size() != 0) ? mq[k][0] : 32'h0);
            chk("cmp_occupancy", 32'(occupancy[k*OW +: OW]), 32'(mq[k].size()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input ch_sel_t s, input logic [W-1:0] d,
                        input logic [3:0] r, input logic f);
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      flush     = f;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 2'd0, '0, 4'b0000, 1'b0);
   endtask

   initial begin
      #12;
      rst_n = 1'b1;
      run = 1'b1;
      tick();
      idle();
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_occupancy", 32'(occupancy), 32'd0);
      chk("reset_out_data0", out_data[31:0], 32'd0);

      // Reset mid-traffic
      drive(1'b1, 2'd1, 32'hAAAA0001, 4'b0000, 1'b0);
      tick();
      idle();
      chk("mid_loaded_valid", 32'(out_valid), 32'b0010);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_async_valid", 32'(out_valid), 32'd0);
      chk("mid_async_data1", out_data[63:32], 32'd0);
      #3;
      rst_n = 1'b1;
      tick();
      idle();
      chk("mid_release_ready", 32'(in_ready), 32'd1);
      chk("mid_release_occ", 32'(occupancy), 32'd0);

      // Single route
      drive(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, 1'b0);
      tick();
      idle();
      chk("route_valid", 32'(out_valid), 32'b0100);
      chk("route_data2", out_data[95:64], 32'hDEADBEEF);
      chk("route_occ2", 32'(occupancy[5:4]), 32'd1);
      drive(1'b0, 2'd0, '0, 4'b0100, 1'b0);
      tick();
      idle();

      // Backpressure on ch0
      drive(1'b1, 2'd0, 32'h1, 4'b0000, 1'b0);
      tick();
      drive(1'b1, 2'd0, 32'h2, 4'b0000, 1'b0);
      tick();
      drive(1'b1, 2'd0, 32'h3, 4'b0000, 1'b0);
      chk("bp_third_refused", 32'(in_ready), 32'd0);
      tick();
      chk("bp_occ_full", 32'(occupancy[1:0]), 32'd2);
      chk("bp_head_1", out_data[31:0], 32'h1);
      drive(1'b1, 2'd0, 32'h3, 4'b0001, 1'b0);
      chk("bp_refused_during_pop", 32'(in_ready), 32'd0);
      tick();
      drive(1'b1, 2'd0, 32'h3, 4'b0000, 1'b0);
      chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
      chk("bp_head_2", out_data[31:0], 32'h2);
      tick();
      drive(1'b0, 2'd0, '0, 4'b0001, 1'b0);
      chk("bp_occ_refilled", 32'(occupancy[1:0]), 32'd2);
      tick();
      chk("bp_head_3", out_data[31:0], 32'h3);
      tick();
      idle();
      chk("bp_drained", 32'(out_valid[0]), 32'd0);

      // Full ch3 with simultaneous push and pop
      drive(1'b1, 2'd3, 32'hC0DE0001, 4'b0000, 1'b0);
      tick();
      drive(1'b1, 2'd3, 32'hC0DE0002, 4'b0000, 1'b0);
      tick();
      drive(1'b1, 2'd3, 32'hC0DE0003, 4'b1000, 1'b0);
      chk("full3_refused", 32'(in_ready), 32'd0);
      chk("full3_occ_before", 32'(occupancy[7:6]), 32'd2);
      tick();
      idle();
      chk("full3_occ_after", 32'(occupancy[7:6]), 32'd1);
      chk("full3_head", out_data[127:96], 32'hC0DE0002);
      drive(1'b0, 2'd0, '0, 4'b1000, 1'b0);
      tick();

      // Isolation: ch0 full and stalled, ch1 still accepts
      drive(1'b1, 2'd0, 32'h10, 4'b0000, 1'b0);
      tick();
      drive(1'b1, 2'd0, 32'h11, 4'b0000, 1'b0);
      tick();
      drive(1'b1, 2'd1, 32'h55, 4'b0000, 1'b0);
      chk("iso_ready", 32'(in_ready), 32'd1);
      tick();
      idle();
      chk("iso_valid1", 32'(out_valid[1]), 32'd1);
      chk("iso_data1", out_data[63:32], 32'h55);

      // Flush precedence with one word per channel
      drive(1'b0, 2'd0, '0, 4'b0000, 1'b1);
      tick();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, ch_sel_t'(k), 32'hF000_0000 + 32'(k), 4'b0000, 1'b0);
         tick();
      end
      idle();
      chk("fl_all_valid", 32'(out_valid), 32'b1111);
      drive(1'b1, 2'd0, 32'h99, 4'b1111, 1'b1);
      chk("fl_ready_low", 32'(in_ready), 32'd0);
      tick();
      idle();
      chk("fl_valid_zero", 32'(out_valid), 32'd0);
      chk("fl_occ_zero", 32'(occupancy), 32'd0);
      drive(1'b1, 2'd0, 32'h77, 4'b0000, 1'b0);
      tick();
      idle();
      chk("post_flush_push", out_data[31:0], 32'h77);
      tick();

      run = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
